// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states, MDU latency default and the per-stage shadow record.
package pipe_pkg;
  localparam int MDU_LAT_DEF = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_LD  = 2'b11
  } fwd_t;

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  typedef struct packed {
    logic       wreg;
    logic [4:0] rn;
    logic       m2reg;
  } shadow_t;
endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Per-operand forwarding select. Also flags a hit on an in-flight load in EX,
// which the top turns into the load-use stall.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       en,
  input  shadow_t    ex,
  input  shadow_t    mem,
  output fwd_t       sel,
  output logic       ld_hit
);
  logic live;

  assign live = en && (src != 5'd0);

  // EX is checked first so the younger producer wins over MEM.
  always_comb begin
    sel = FWD_RF;
    if (!live)                                 sel = FWD_RF;
    else if (ex.wreg && ex.rn == src && !ex.m2reg) sel = FWD_EX;
    else if (mem.wreg && mem.rn == src && mem.m2reg) sel = FWD_LD;
    else if (mem.wreg && mem.rn == src)        sel = FWD_MEM;
  end

  assign ld_hit = live && ex.wreg && ex.m2reg && (ex.rn == src);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, jump flush
// and multi-cycle mul/div stall FSM with EX/MEM shadow registers.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic [4:0] id_rn,
  input  logic       id_m2reg,
  input  logic       id_mdu,
  input  logic       id_jump,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       wpcir,
  output logic       bubble,
  output logic       flush,
  output logic       mdu_busy
);
  generate
    if (MDU_LAT < 2 || MDU_LAT > 15) begin : g_bad_lat
      $error("pipe_ctrl: MDU_LAT must be in 2..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 2);

  state_t     state, state_nx;
  logic [3:0] count, count_nx;
  shadow_t    ex, mem;
  fwd_t       sela, selb;
  logic       hita, hitb, lu;

  fwd_sel u_fwd_rs (.src(id_rs), .en(id_use_rs), .ex(ex), .mem(mem), .sel(sela), .ld_hit(hita));
  fwd_sel u_fwd_rt (.src(id_rt), .en(id_use_rt), .ex(ex), .mem(mem), .sel(selb), .ld_hit(hitb));

  assign fwda = sela;
  assign fwdb = selb;
  assign lu   = hita | hitb;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RUN;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // The stall wins over a jump: the jump stays in IF/ID and is re-presented.
  always_comb begin
    state_nx = state;
    count_nx = count;
    wpcir    = 1'b1;
    bubble   = 1'b0;
    flush    = 1'b0;
    mdu_busy = 1'b0;
    case (state)
      RUN: begin
        if (lu) begin
          wpcir  = 1'b0;
          bubble = 1'b1;
        end else begin
          flush = id_jump;
          if (id_mdu) begin
            state_nx = MDU;
            count_nx = CNT_INIT;
          end
        end
      end
      MDU: begin
        wpcir    = 1'b0;
        bubble   = 1'b1;
        mdu_busy = 1'b1;
        if (count == 4'd0) state_nx = RUN;
        else               count_nx = count - 4'd1;
      end
      default: state_nx = RUN;
    endcase
  end

  // While the MDU occupies EX, the EX shadow holds and MEM sees only bubbles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ex  <= '0;
      mem <= '0;
    end else if (state == RUN) begin
      ex.wreg  <= id_wreg & ~bubble;
      ex.rn    <= id_rn;
      ex.m2reg <= id_m2reg;
      mem      <= ex;
    end else begin
      mem.wreg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load-use, MDU stall, jump/stall
// interaction, r0 handling, EX-over-MEM priority and reset during MDU.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_rn = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0;
  logic       id_m2reg = 1'b0, id_mdu = 1'b0, id_jump = 1'b0;
  logic [1:0] fwda, fwdb;
  logic       wpcir, bubble, flush, mdu_busy;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MDU_LAT(8)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn), .id_m2reg(id_m2reg), .id_mdu(id_mdu),
    .id_jump(id_jump),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble), .flush(flush),
    .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and step just past it before touching inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic wreg, input logic [4:0] rn,
                        input logic m2reg, input logic mdu, input logic jump);
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wreg = wreg; id_rn = rn; id_m2reg = m2reg; id_mdu = mdu; id_jump = jump;
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    set_id(5'd3, 1, 5'd4, 1, 1, 5'd3, 0, 0, 1);
    checks++;
    if ({wpcir, bubble, mdu_busy, fwda, fwdb, flush} !== 8'b1_0_0_00_00_1) begin
      errors++;
      $display("FAIL reset_outputs: got w=%b b=%b busy=%b fa=%b fb=%b fl=%b, want w=1 b=0 busy=0 fa=00 fb=00 fl=1",
               wpcir, bubble, mdu_busy, fwda, fwdb, flush);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    drain();
  endtask

  task automatic test_alu_chain();
    set_id(5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    tick();
    set_id(5'd3, 1, 5'd2, 1, 1, 5'd4, 0, 0, 0);
    checks++;
    if (fwda !== 2'b01 || wpcir !== 1'b1) begin
      errors++;
      $display("FAIL alu_ex_fwd: got fwda=%b wpcir=%b, want fwda=01 wpcir=1", fwda, wpcir);
    end
    tick();
    set_id(5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    checks++;
    if (fwda !== 2'b10 || wpcir !== 1'b1) begin
      errors++;
      $display("FAIL alu_mem_fwd: got fwda=%b wpcir=%b, want fwda=10 wpcir=1", fwda, wpcir);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_id(5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0);
    tick();
    set_id(5'd1, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0);
    checks++;
    if (wpcir !== 1'b0 || bubble !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got wpcir=%b bubble=%b, want wpcir=0 bubble=1", wpcir, bubble);
    end
    tick();
    checks++;
    if (fwdb !== 2'b11 || wpcir !== 1'b1 || bubble !== 1'b0) begin
      errors++;
      $display("FAIL lu_resume: got fwdb=%b wpcir=%b bubble=%b, want fwdb=11 wpcir=1 bubble=0",
               fwdb, wpcir, bubble);
    end
    drain();
  endtask

  task automatic test_mdu();
    int busy_cnt;
    busy_cnt = 0;
    set_id(5'd1, 1, 5'd2, 1, 1, 5'd9, 0, 1, 0);
    checks++;
    if (wpcir !== 1'b1 || mdu_busy !== 1'b0) begin
      errors++;
      $display("FAIL mdu_issue: got wpcir=%b busy=%b, want wpcir=1 busy=0", wpcir, mdu_busy);
    end
    tick();
    // Next instruction waits in ID, with a jump and mdu bit that must be ignored.
    set_id(5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    for (int i = 0; i < 20 && mdu_busy === 1'b1; i++) begin
      if (wpcir !== 1'b0 || bubble !== 1'b1 || flush !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL mdu_stall_cycle%0d: got wpcir=%b bubble=%b flush=%b, want 0 1 0",
                 i, wpcir, bubble, flush);
      end
      busy_cnt++;
      if (busy_cnt == 7) set_id(5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
      tick();
    end
    checks++;
    if (busy_cnt != 7) begin
      errors++;
      $display("FAIL mdu_busy_len: got %0d cycles, want 7", busy_cnt);
    end
    checks++;
    if (wpcir !== 1'b1 || mdu_busy !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL mdu_return: got wpcir=%b busy=%b flush=%b, want 1 0 1", wpcir, mdu_busy, flush);
    end
    drain();
  endtask

  task automatic test_jump_stall();
    set_id(5'd1, 1, 5'd0, 0, 1, 5'd6, 1, 0, 0);
    tick();
    set_id(5'd6, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    checks++;
    if (flush !== 1'b0 || wpcir !== 1'b0) begin
      errors++;
      $display("FAIL jump_during_lu: got flush=%b wpcir=%b, want flush=0 wpcir=0", flush, wpcir);
    end
    tick();
    checks++;
    if (flush !== 1'b1 || wpcir !== 1'b1) begin
      errors++;
      $display("FAIL jump_after_lu: got flush=%b wpcir=%b, want flush=1 wpcir=1", flush, wpcir);
    end
    drain();
  endtask

  task automatic test_r0_priority();
    set_id(5'd1, 1, 5'd0, 0, 1, 5'd0, 1, 0, 0);
    tick();
    set_id(5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 0);
    checks++;
    if (fwda !== 2'b00 || fwdb !== 2'b00 || wpcir !== 1'b1) begin
      errors++;
      $display("FAIL r0_reader: got fwda=%b fwdb=%b wpcir=%b, want 00 00 1", fwda, fwdb, wpcir);
    end
    drain();
    set_id(5'd1, 1, 5'd0, 0, 1, 5'd7, 0, 0, 0);
    tick();
    set_id(5'd2, 1, 5'd0, 0, 1, 5'd7, 0, 0, 0);
    tick();
    set_id(5'd7, 1, 5'd7, 0, 0, 5'd0, 0, 0, 0);
    checks++;
    if (fwda !== 2'b01 || fwdb !== 2'b00) begin
      errors++;
      $display("FAIL ex_over_mem: got fwda=%b fwdb=%b, want fwda=01 fwdb=00", fwda, fwdb);
    end
    drain();
  endtask

  task automatic test_reset_mdu();
    set_id(5'd1, 1, 5'd2, 1, 1, 5'd9, 0, 1, 0);
    tick();
    set_id(5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    tick(); tick(); tick();
    checks++;
    if (mdu_busy !== 1'b1) begin
      errors++;
      $display("FAIL mdu_before_clr: got busy=%b, want 1", mdu_busy);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || wpcir !== 1'b1) begin
      errors++;
      $display("FAIL clr_mid_mdu: got busy=%b wpcir=%b, want busy=0 wpcir=1", mdu_busy, wpcir);
    end
    #1;
    clr = 1'b0;
    tick();
    checks++;
    if (wpcir !== 1'b1 || mdu_busy !== 1'b0 || bubble !== 1'b0) begin
      errors++;
      $display("FAIL after_clr: got wpcir=%b busy=%b bubble=%b, want 1 0 0", wpcir, mdu_busy, bubble);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mdu();
    test_jump_stall();
    test_r0_priority();
    test_reset_mdu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 8: EX occupancy in cycles of a multi-cycle mul/div op; legal range 2..15.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port clr  in  1: asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each: source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs, id_use_rt  in  1 each: the ID instruction actually reads rs / rt.
REQ-006 SHALL have ports id_wreg  in  1 and id_rn  in  5: the ID instruction writes the register file, and its destination number.
REQ-007 SHALL have port id_m2reg  in  1: the ID instruction is a load.
REQ-008 SHALL have port id_mdu  in  1: the ID instruction is a multi-cycle mul/div.
REQ-009 SHALL have port id_jump  in  1: the ID instruction redirects the PC (taken branch or jump, pcsource != 00).
REQ-010 SHALL have ports fwda, fwdb  out  2 each: operand source select; 00 = regfile, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
REQ-011 SHALL have port wpcir  out  1: PC and IF/ID write enable; 0 = hold.
REQ-012 SHALL have port bubble  out  1: zero the ID/EX control bits this cycle.
REQ-013 SHALL have port flush  out  1: kill the IF/ID instruction.
REQ-014 SHALL have port mdu_busy  out  1: FSM is in state MDU.

Function
REQ-015 SHALL keep shadow registers ex_{wreg,rn,m2reg} and mem_{wreg,rn,m2reg}, which track the ID/EX and EX/MEM stages.
REQ-016 SHALL, in state RUN, load ex_* from id_* on every edge, with ex_wreg forced to 0 when bubble=1; mem_* SHALL load ex_*.
REQ-017 SHALL, in state MDU, hold ex_* unchanged and clear mem_wreg to 0.
REQ-018 SHALL compute fwda combinationally, in this priority order:
- 00 if id_use_rs=0 or id_rs=0;
- else 01 if ex_wreg, ex_rn=id_rs and !ex_m2reg;
- else 11 if mem_wreg, mem_rn=id_rs and mem_m2reg;
- else 10 if mem_wreg and mem_rn=id_rs;
- else 00.
REQ-019 SHALL compute fwdb in the same way, using id_rt and id_use_rt.
REQ-020 SHALL assert load-use hazard lu, combinationally, when ex_wreg & ex_m2reg and ex_rn != 0, and ex_rn matches an id_rs or id_rt that is used.
REQ-021 SHALL drive, in RUN with lu=1: wpcir=0, bubble=1, flush=0, and no MDU entry; the stall lasts exactly one cycle per load.
REQ-022 SHALL drive, in RUN with lu=0: wpcir=1, bubble=0, flush=id_jump.
REQ-023 SHALL, in RUN with lu=0 and id_mdu=1, go to state MDU at the next edge and load count = MDU_LAT-2.
REQ-024 SHALL drive, in MDU: wpcir=0, bubble=1, flush=0, mdu_busy=1; id_jump and id_mdu SHALL be ignored.
REQ-025 SHALL, in MDU, decrement count each cycle and return to RUN on the edge where count=0.
- Total stall is MDU_LAT-1 cycles after the issue cycle.
REQ-026 SHALL use 4-bit unsigned count, never wrap below 0, and treat MDU_LAT outside 2..15 as an elaboration error.
REQ-027 SHALL, when lu=1 and id_jump=1 in the same cycle, give priority to the stall: flush=0, and the jump is re-presented next cycle.
REQ-028 SHALL give EX forwarding priority over MEM when both hold the same destination register.

Reset
REQ-029 SHALL, while clr=1, asynchronously force: state=RUN, count=0, all shadow wreg/m2reg bits=0, rn=0.
REQ-030 SHALL produce these outputs from the reset state: wpcir=1, bubble=0, mdu_busy=0, fwda=fwdb=00, flush=id_jump.
REQ-031 SHALL, on reset during MDU, abandon the op with no further stall cycles.

Structure
REQ-032 SHALL take from shared package pipe_pkg:
- fwd select encodings FWD_RF/FWD_EX/FWD_MEM/FWD_LD;
- state encoding RUN/MDU;
- the MDU_LAT default.
REQ-033 SHALL instantiate sub-module fwd_sel twice (rs, rt).
- fwd_sel is combinational: it maps one source number, use bit and the shadow registers to a 2-bit select plus a load-hit flag.
REQ-034 SHALL contain the FSM, the counter and the shadow registers in pipe_ctrl itself.

Verification
REQ-035 ALU chain: add r3 then sub using r3 as rs, next cycle -> fwda=01, wpcir=1; one cycle later with r3 in MEM -> fwda=10.
REQ-036 Load-use: lw r5 then add reading r5 as rt -> one cycle with wpcir=0, bubble=1; next cycle fwdb=11, wpcir=1.
REQ-037 MDU with MDU_LAT=8: id_mdu=1 in RUN -> mdu_busy=1 for exactly 7 cycles, wpcir=0 throughout, then RUN with wpcir=1.
REQ-038 Jump vs stall: lu=1 and id_jump=1 together -> flush=0; next cycle lu=0 -> flush=1.
REQ-039 r0 and priority:
- writer to r0 followed by a reader of r0 -> fwda=00 and no stall;
- r7 in both EX (ALU) and MEM -> fwda=01.
REQ-040 Reset mid-MDU: assert clr at count=3 -> state RUN, mdu_busy=0 immediately; after clr release, wpcir=1.
